// File: rtl/rec_adc_sequencer.sv
// Recording-ADC sequencer: scans masked mux channels, runs N_ADC serial SAR
// conversions in parallel and presents one parallel word per channel on valid/ready.
module rec_adc_sequencer #(
  parameter int unsigned N_ADC      = 2,
  parameter int unsigned N_CH       = 32,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned RES_W      = 10,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned SAMPLE_CYC = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [N_CH-1:0]          ch_mask_i,
  input  logic [N_ADC-1:0]         adc_res_i,
  output logic                     adc_en_o,
  output logic                     sample_o,
  output logic [IDX_W-1:0]         mux_idx_o,
  output logic [N_ADC*RES_W-1:0]   data_o,
  output logic [IDX_W-1:0]         data_ch_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     frame_o,
  output logic                     ovf_o
);

  localparam int unsigned MAX_SS = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int unsigned MAXC   = (MAX_SS > RES_W) ? MAX_SS : RES_W;
  localparam int unsigned CNT_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_CONVERT,
    S_STORE
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [N_CH-1:0]                r_mask;
  logic                           r_en_d;
  logic [N_ADC-1:0][RES_W-1:0]    r_sr;

  logic                           w_first_vld;
  logic [IDX_W-1:0]               w_first_idx;
  logic                           w_next_vld;
  logic [IDX_W-1:0]               w_next_idx;

  // Lowest set bit of the incoming mask, and next set bit of the latched mask
  // above the current channel; no next bit means the current channel ends the sweep.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_mask_i[i] && !w_first_vld) begin
        w_first_vld = 1'b1;
        w_first_idx = IDX_W'(i);
      end
      if (r_mask[i] && (i > 32'(mux_idx_o)) && !w_next_vld) begin
        w_next_vld = 1'b1;
        w_next_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_en_d       <= 1'b0;
      r_sr         <= '0;
      adc_en_o     <= 1'b0;
      sample_o     <= 1'b0;
      mux_idx_o    <= '0;
      data_o       <= '0;
      data_ch_o    <= '0;
      data_valid_o <= 1'b0;
      frame_o      <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      r_en_d  <= enable_i;
      frame_o <= 1'b0;
      if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
      if (enable_i && !r_en_d) begin
        ovf_o <= 1'b0;
      end

      // Disable wins over every active state, including STORE: the
      // in-flight conversion is abandoned while any pending output word stays.
      if (r_state != S_IDLE && !enable_i) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        adc_en_o <= 1'b0;
        sample_o <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable_i && w_first_vld) begin
              r_mask    <= ch_mask_i;
              mux_idx_o <= w_first_idx;
              r_cnt     <= '0;
              adc_en_o  <= 1'b1;
              r_state   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
              r_cnt    <= '0;
              sample_o <= 1'b1;
              r_state  <= S_SAMPLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            if (r_cnt == CNT_W'(SAMPLE_CYC - 1)) begin
              r_cnt    <= '0;
              sample_o <= 1'b0;
              r_state  <= S_CONVERT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_CONVERT: begin
            for (int unsigned a = 0; a < N_ADC; a++) begin
              r_sr[a] <= {r_sr[a][RES_W-2:0], adc_res_i[a]};
            end
            if (r_cnt == CNT_W'(RES_W - 1)) begin
              r_cnt   <= '0;
              r_state <= S_STORE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_STORE: begin
            if (!data_valid_o || data_ready_i) begin
              data_o       <= r_sr;
              data_ch_o    <= mux_idx_o;
              data_valid_o <= 1'b1;
              frame_o      <= !w_next_vld;
            end else begin
              ovf_o <= 1'b1;
            end
            if (w_next_vld) begin
              mux_idx_o <= w_next_idx;
              r_state   <= S_SETTLE;
            end else begin
              r_mask <= ch_mask_i;
              if (w_first_vld) begin
                mux_idx_o <= w_first_idx;
                r_state   <= S_SETTLE;
              end else begin
                adc_en_o <= 1'b0;
                r_state  <= S_IDLE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
